// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: drains 8-bit grayscale pixels from a FWFT FIFO and
// writes a 24-bit BMP byte stream (header, B/G/R triplets, row padding)
// into a byte FIFO, frame after frame with no gaps.
// Build option: define BMP_HEADER_GEN_EN to prepend the 54-byte BMP header
// to every frame; when undefined, frames consist of pixel and pad bytes only.
module bmp_stream_writer #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_empty,
    input  logic [7:0] in_dout,
    output logic       in_rd_en,
    input  logic       out_full,
    output logic       out_wr_en,
    output logic [7:0] out_din,
    output logic       frame_done
);

    // Geometry, computed in 32-bit arithmetic
    localparam int unsigned CW     = $clog2(WIDTH) + 1;
    localparam int unsigned RW     = $clog2(HEIGHT) + 1;
    localparam logic [31:0] W32    = 32'(WIDTH);
    localparam logic [31:0] H32    = 32'(HEIGHT);
    localparam logic [31:0] STRIDE = (32'd3 * W32 + 32'd3) & ~32'd3;
    localparam logic [31:0] IMG    = STRIDE * H32;
    localparam logic [31:0] PAD    = STRIDE - 32'd3 * W32;

    localparam logic [1:0]    PAD_LAST = PAD[1:0] - 2'd1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

`ifdef BMP_HEADER_GEN_EN
    localparam logic [31:0] FSIZE = 32'd54 + IMG;

    // Header image, byte 0 in the least significant byte; multi-byte fields
    // are therefore little-endian by construction.
    localparam logic [431:0] HDR_BYTES = {
        128'd0,          // bytes 38..53: resolution / palette fields
        IMG,             // bytes 34..37: image size
        32'd0,           // bytes 30..33: compression
        16'd24,          // bytes 28..29: bits per pixel
        16'd1,           // bytes 26..27: planes
        H32,             // bytes 22..25: height
        W32,             // bytes 18..21: width
        32'd40,          // bytes 14..17: info header size
        32'd54,          // bytes 10..13: pixel data offset
        32'd0,           // bytes  6..9 : reserved
        FSIZE,           // bytes  2..5 : file size
        8'h4D, 8'h42     // bytes  0..1 : "BM"
    };

    typedef enum logic [1:0] {
        S_HDR,
        S_PIX,
        S_PAD
    } state_t;

    localparam state_t FRAME_START = S_HDR;
`else
    typedef enum logic [1:0] {
        S_PIX,
        S_PAD
    } state_t;

    localparam state_t FRAME_START = S_PIX;
`endif

    state_t        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] col_q,   col_d;
    logic [RW-1:0] row_q,   row_d;
    logic [1:0]    pad_q,   pad_d;
    logic          frame_done_q, frame_done_d;
    logic          row_end;
`ifdef BMP_HEADER_GEN_EN
    logic [5:0]    hdr_idx_q, hdr_idx_d;
`endif

    // State and counter registers; reset abandons any partial frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FRAME_START;
            phase_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pad_q        <= '0;
            frame_done_q <= 1'b0;
`ifdef BMP_HEADER_GEN_EN
            hdr_idx_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pad_q        <= pad_d;
            frame_done_q <= frame_done_d;
`ifdef BMP_HEADER_GEN_EN
            hdr_idx_q    <= hdr_idx_d;
`endif
        end
    end

    // Next-state and FIFO strobes; every transition is qualified by the write
    // actually happening, so stalls freeze the whole machine in place.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        col_d        = col_q;
        row_d        = row_q;
        pad_d        = pad_q;
        frame_done_d = 1'b0;
        row_end      = 1'b0;
        in_rd_en     = 1'b0;
        out_wr_en    = 1'b0;
        out_din      = '0;
`ifdef BMP_HEADER_GEN_EN
        hdr_idx_d    = hdr_idx_q;
`endif

        if (!reset) begin
            case (state_q)
`ifdef BMP_HEADER_GEN_EN
                S_HDR: begin
                    out_din = HDR_BYTES[{hdr_idx_q, 3'b000} +: 8];
                    if (!out_full) begin
                        out_wr_en = 1'b1;
                        if (hdr_idx_q == 6'd53) begin
                            hdr_idx_d = '0;
                            state_d   = S_PIX;
                        end else begin
                            hdr_idx_d = hdr_idx_q + 6'd1;
                        end
                    end
                end
`endif
                S_PIX: begin
                    // FIFO head is only looked at while it is valid
                    if (!in_empty) begin
                        out_din = in_dout;
                        if (!out_full) begin
                            out_wr_en = 1'b1;
                            if (phase_q == 2'd2) begin
                                in_rd_en = 1'b1;
                                phase_d  = '0;
                                if (col_q == COL_LAST) begin
                                    col_d = '0;
                                    if (PAD != 32'd0) begin
                                        state_d = S_PAD;
                                    end else begin
                                        row_end = 1'b1;
                                    end
                                end else begin
                                    col_d = col_q + CW'(1);
                                end
                            end else begin
                                phase_d = phase_q + 2'd1;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (!out_full) begin
                        out_wr_en = 1'b1;
                        if (pad_q == PAD_LAST) begin
                            pad_d   = '0;
                            row_end = 1'b1;
                        end else begin
                            pad_d = pad_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_d = FRAME_START;
                end
            endcase

            // Row end is folded into the cycle of the row's last byte so
            // consecutive rows and frames stream without a bubble.
            if (row_end) begin
                if (row_q == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = FRAME_START;
                end else begin
                    row_d   = row_q + RW'(1);
                    state_d = S_PIX;
                end
            end
        end
    end

    assign frame_done = frame_done_q;

endmodule
